// File: rtl/sram_arbiter.sv
// Two-master arbiter sharing one SRAM-like port between fetch and data.
// Ports: clk/reset, inst_* and data_* master sides, mem_* memory side.
// Optional ARB_ROUND_ROBIN_EN: on a tie the master not granted last wins.
module sram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_gnt_data;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_any;
  logic        w_pick_data;
  logic        w_addr_ok;
  logic        w_data_ok;

  assign w_any = inst_req | data_req;

  // r_gnt_data doubles as the last-grant record for round robin
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    w_pick_data = data_req & (~inst_req | ~r_gnt_data);
`else
    w_pick_data = data_req;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_any) w_next = S_REQ;
      S_REQ:  if (mem_addr_ok) w_next = S_RESP;
      S_RESP: if (mem_data_ok) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt_data <= 1'b0;
      r_wr       <= 1'b0;
      r_size     <= 2'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
    end else if (r_state == S_IDLE && w_any) begin
      r_gnt_data <= w_pick_data;
      r_wr       <= w_pick_data ? data_wr    : inst_wr;
      r_size     <= w_pick_data ? data_size  : inst_size;
      r_addr     <= w_pick_data ? data_addr  : inst_addr;
      r_wdata    <= w_pick_data ? data_wdata : inst_wdata;
    end
  end

  always_comb begin
    mem_req      = 1'b0;
    w_addr_ok    = 1'b0;
    w_data_ok    = 1'b0;
    unique case (r_state)
      S_REQ: begin
        mem_req   = 1'b1;
        w_addr_ok = mem_addr_ok;
      end
      S_RESP: w_data_ok = mem_data_ok;
      default: ;
    endcase
    inst_addr_ok = w_addr_ok & ~r_gnt_data;
    data_addr_ok = w_addr_ok &  r_gnt_data;
    inst_data_ok = w_data_ok & ~r_gnt_data;
    data_data_ok = w_data_ok &  r_gnt_data;
    inst_rdata   = inst_data_ok ? mem_rdata : 32'd0;
    data_rdata   = data_data_ok ? mem_rdata : 32'd0;
  end

  assign mem_wr    = r_wr;
  assign mem_size  = r_size;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: vector table, directed corners,
// and randomized traffic against a transaction-level reference model.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int n_pass = 0;
  int n_tot  = 0;

  sram_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: one transaction in flight, tracked as
  // "pending" (busy) and "address accepted" (acc), plus its owner.
  logic        m_busy = 0, m_acc = 0, m_own = 0, m_wr = 0;
  logic [1:0]  m_size = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;

  function automatic logic pick_data();
    if (inst_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      return !m_own;
`else
      return 1'b1;
`endif
    end
    return data_req;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 0; m_acc <= 0; m_own <= 0; m_wr <= 0;
      m_size <= 0; m_addr <= 0; m_wdata <= 0;
    end else if (!m_busy) begin
      if (inst_req || data_req) begin
        m_own   <= pick_data();
        m_wr    <= pick_data() ? data_wr    : inst_wr;
        m_size  <= pick_data() ? data_size  : inst_size;
        m_addr  <= pick_data() ? data_addr  : inst_addr;
        m_wdata <= pick_data() ? data_wdata : inst_wdata;
        m_busy  <= 1;
        m_acc   <= 0;
      end
    end else if (!m_acc) begin
      if (mem_addr_ok) m_acc <= 1;
    end else if (mem_data_ok) begin
      m_busy <= 0;
    end
  end

  function automatic logic [135:0] outs();
    return {mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
            inst_addr_ok, inst_data_ok, inst_rdata,
            data_addr_ok, data_data_ok, data_rdata};
  endfunction

  function automatic logic [135:0] exp_outs();
    logic mreq, aok, dok;
    mreq = m_busy && !m_acc;
    aok  = mreq && mem_addr_ok;
    dok  = m_busy && m_acc && mem_data_ok;
    return {mreq, m_wr, m_size, m_addr, m_wdata,
            aok && !m_own, dok && !m_own,
            (dok && !m_own) ? mem_rdata : 32'd0,
            aok && m_own, dok && m_own,
            (dok && m_own) ? mem_rdata : 32'd0};
  endfunction

  task automatic chk(input string nm, input logic [135:0] got,
                     input logic [135:0] exp);
    n_tot++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    else
      n_pass++;
  endtask

  task automatic settle(input string nm);
    #1;
    chk(nm, outs(), exp_outs());
  endtask

  task automatic idle_in();
    inst_req = 0; data_req = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  typedef struct {
    logic ir, dr, aok, dok;
    logic [31:0] rd;
    logic e_mreq;
    logic [31:0] e_addr;
    logic e_iaok, e_idok;
    logic [31:0] e_ird;
    logic e_daok, e_ddok;
    logic [31:0] e_drd;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int gc[$];
    bit gw[$];

    tbl[0]  = '{1,0,0,0,32'h0,        0,32'h0,        0,0,32'h0,        0,0,32'h0};
    tbl[1]  = '{1,0,0,0,32'h0,        1,32'hBFC00000, 0,0,32'h0,        0,0,32'h0};
    tbl[2]  = '{1,0,0,1,32'h11,       1,32'hBFC00000, 0,0,32'h0,        0,0,32'h0};
    tbl[3]  = '{1,0,1,0,32'h0,        1,32'hBFC00000, 1,0,32'h0,        0,0,32'h0};
    tbl[4]  = '{0,0,0,0,32'h0,        0,32'hBFC00000, 0,0,32'h0,        0,0,32'h0};
    tbl[5]  = '{0,0,0,0,32'h0,        0,32'hBFC00000, 0,0,32'h0,        0,0,32'h0};
    tbl[6]  = '{0,0,0,1,32'h12345678, 0,32'hBFC00000, 0,1,32'h12345678, 0,0,32'h0};
    tbl[7]  = '{0,0,0,0,32'h0,        0,32'hBFC00000, 0,0,32'h0,        0,0,32'h0};
    tbl[8]  = '{1,1,0,0,32'h0,        0,32'hBFC00000, 0,0,32'h0,        0,0,32'h0};
    tbl[9]  = '{1,1,1,0,32'h0,        1,32'h80001000, 0,0,32'h0,        1,0,32'h0};
    tbl[10] = '{1,0,0,1,32'hAABBCCDD, 0,32'h80001000, 0,0,32'h0,        0,1,32'hAABBCCDD};
    tbl[11] = '{1,0,0,0,32'h0,        0,32'h80001000, 0,0,32'h0,        0,0,32'h0};
    tbl[12] = '{1,0,1,0,32'h0,        1,32'hBFC00000, 1,0,32'h0,        0,0,32'h0};
    tbl[13] = '{0,0,0,1,32'h55,       0,32'hBFC00000, 0,1,32'h55,       0,0,32'h0};
    tbl[14] = '{0,0,1,1,32'h66,       0,32'hBFC00000, 0,0,32'h0,        0,0,32'h0};

    reset = 1;
    idle_in();
    inst_wr = 0; inst_size = 2; inst_addr = 32'hBFC00000; inst_wdata = 0;
    data_wr = 0; data_size = 2; data_addr = 32'h80001000; data_wdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", outs(), 136'd0);
    reset = 0;

    // table: single fetch, simultaneous requests, stray acks
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      inst_req = tbl[i].ir; data_req = tbl[i].dr;
      mem_addr_ok = tbl[i].aok; mem_data_ok = tbl[i].dok;
      mem_rdata = tbl[i].rd;
      #1;
      chk($sformatf("tbl%0d", i),
          {mem_req, mem_addr, inst_addr_ok, inst_data_ok, inst_rdata,
           data_addr_ok, data_data_ok, data_rdata},
          {tbl[i].e_mreq, tbl[i].e_addr, tbl[i].e_iaok, tbl[i].e_idok,
           tbl[i].e_ird, tbl[i].e_daok, tbl[i].e_ddok, tbl[i].e_drd});
      chk($sformatf("tbl%0d_model", i), outs(), exp_outs());
    end

    // store
    @(negedge clk);
    idle_in();
    data_req = 1; data_wr = 1; data_size = 2;
    data_addr = 32'h00001000; data_wdata = 32'hDEADBEEF;
    settle("st_c0");
    @(negedge clk);
    mem_addr_ok = 1;
    settle("st_c1");
    chk("st_fields",
        {mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
         data_addr_ok, inst_addr_ok},
        {1'b1, 1'b1, 2'd2, 32'h00001000, 32'hDEADBEEF, 1'b1, 1'b0});
    @(negedge clk);
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 0;
    settle("st_c2");
    chk("st_resp", {data_data_ok, data_rdata, inst_data_ok},
        {1'b1, 32'd0, 1'b0});
    @(negedge clk);
    idle_in();
    data_wr = 0;
    settle("st_c3");
    chk("st_done", {data_addr_ok, data_data_ok}, 2'b00);

    // reset while waiting for the response
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h00001234;
    settle("rr_c0");
    @(negedge clk);
    mem_addr_ok = 1;
    settle("rs_c1");
    chk("rs_aok", inst_addr_ok, 1);
    @(negedge clk);
    inst_req = 0; mem_addr_ok = 0; reset = 1;
    settle("rs_c2");
    @(negedge clk);
    reset = 0; mem_data_ok = 1; mem_rdata = 32'h77;
    settle("rs_c3");
    chk("rs_all_zero", outs(), 136'd0);
    @(negedge clk);
    mem_data_ok = 0; inst_req = 1; inst_addr = 32'h00002000;
    settle("rs_c4");
    @(negedge clk);
    mem_addr_ok = 1;
    settle("rs_c5");
    chk("rs_new_req", {mem_req, mem_addr, inst_addr_ok},
        {1'b1, 32'h00002000, 1'b1});
    @(negedge clk);
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h88;
    settle("rs_c6");
    chk("rs_new_resp", {inst_data_ok, inst_rdata}, {1'b1, 32'h88});

    // requester drops req right after latch
    @(negedge clk);
    idle_in();
    inst_req = 1; inst_addr = 32'hBFC00010;
    settle("dr_c0");
    @(negedge clk);
    inst_req = 0;
    settle("dr_c1");
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dr_hold%0d", k), mem_req, 1);
      @(negedge clk);
      settle("dr_wait");
    end
    chk("dr_hold3", mem_req, 1);
    @(negedge clk);
    mem_addr_ok = 1;
    settle("dr_c5");
    chk("dr_aok", {mem_req, mem_addr, inst_addr_ok},
        {1'b1, 32'hBFC00010, 1'b1});
    @(negedge clk);
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hCAFE;
    settle("dr_c6");
    chk("dr_dok", {inst_data_ok, inst_rdata, data_data_ok},
        {1'b1, 32'hCAFE, 1'b0});

    // continuous contention with immediate memory acks
    @(negedge clk);
    idle_in();
    reset = 1;
    settle("cc_rst");
    @(negedge clk);
    reset = 0;
    for (int c = 0; c < 13; c++) begin
      if (c > 0) @(negedge clk);
      inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
      mem_rdata = 32'h100 + c;
      settle("cc");
      if (inst_addr_ok || data_addr_ok) begin
        gc.push_back(c);
        gw.push_back(data_addr_ok);
      end
    end
    chk("cc_count", gc.size() >= 4, 1);
    for (int k = 0; k < 4; k++) begin
      if (k < gc.size()) begin
`ifdef ARB_ROUND_ROBIN_EN
        chk($sformatf("cc_grant%0d", k), gw[k], (k % 2) == 0);
`else
        chk($sformatf("cc_grant%0d", k), gw[k], 1);
`endif
        chk($sformatf("cc_cycle%0d", k), gc[k], 1 + 3 * k);
      end
    end

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      reset       = ($urandom_range(63) == 0);
      inst_req    = $urandom_range(1);
      data_req    = $urandom_range(1);
      inst_wr     = $urandom_range(1);
      data_wr     = $urandom_range(1);
      inst_size   = 2'($urandom_range(2));
      data_size   = 2'($urandom_range(2));
      inst_addr   = $urandom;
      data_addr   = $urandom;
      inst_wdata  = $urandom;
      data_wdata  = $urandom;
      mem_addr_ok = ($urandom_range(9) < 4);
      mem_data_ok = ($urandom_range(9) < 4);
      mem_rdata   = $urandom;
      settle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
